pattern_detector_param: RTL

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

---
 rtl/pattern_detector_param.sv | 95 +++++++++
 1 files changed

// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
//
// Serial pattern detector. Accepted bits (valid_i=1 on a rising edge) shift
// into a PAT_W-bit history. A match fires when at least PAT_W bits have been
// accepted and the newest PAT_W bits equal pattern_i (MSB = oldest bit).
// Overlapping or non-overlapping detection is selected per bit by overlap_i.
// Matches produce a one-cycle registered pulse and bump a saturating counter.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : synchronous active-high reset
//   valid_i      : qualifies d_i
//   d_i          : serial data bit
//   pattern_i    : PAT_W-bit target pattern, [PAT_W-1] earliest in time
//   overlap_i    : 1 = overlapping detection, 0 = non-overlapping
//   clear_i      : synchronous clear of the match counter only
//   pattern_o    : one-cycle match pulse, one clock after the matching bit
//   match_cnt_o  : saturating count of matches
// -----------------------------------------------------------------------------
module pattern_detector_param #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              d_i,
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic              overlap_i,
  input  logic              clear_i,
  output logic              pattern_o,
  output logic [CNT_W-1:0]  match_cnt_o
);

  // Fill must represent 0..PAT_W inclusive.
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  hist_q,    hist_d;
  logic [FILL_W-1:0] fill_q,    fill_d;
  logic              pattern_q, pattern_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic [PAT_W-1:0]  window;
  logic              match;

  always_comb begin
    window = {hist_q[PAT_W-2:0], d_i};
    // fill+1 >= PAT_W is the same as fill >= PAT_W-1, avoiding an extra bit.
    match  = valid_i && (fill_q >= FILL_NEAR) && (window == pattern_i);

    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = match;

    if (valid_i) begin
      hist_d = window;
      if (match && !overlap_i) begin
        // Non-overlapping: the next match needs PAT_W fresh bits.
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    // Clear wins over the old value but still counts a coincident match.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pattern_o   = pattern_q;
  assign match_cnt_o = cnt_q;

endmodule
